// File: rtl/rab_pkg.sv
// Shared types for the RAB write-port response block: FSM states and AXI response codes.
package rab_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FWD_AW = 3'd1,
    FWD_W  = 3'd2,
    DROP_W = 3'd3,
    DROP_B = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // A miss means no entry matched at all (SLVERR); otherwise the hit was disallowed (DECERR).
  function automatic logic [1:0] drop_resp(input logic miss);
    return miss ? RESP_SLVERR : RESP_DECERR;
  endfunction

endpackage

// File: rtl/rab_wr_port_resp_if.sv
// Bundle of lookup-decision, master AW/W, slave W/B and status signals for one RAB write port.
interface rab_wr_port_resp_if #(
  parameter int AXI_ADDR_WIDTH = 40,
  parameter int AXI_ID_WIDTH   = 8
);

  logic                      accept_i;
  logic                      drop_i;
  logic                      miss_i;
  logic [AXI_ADDR_WIDTH-1:0] out_addr_i;
  logic                      coherent_i;
  logic [AXI_ID_WIDTH-1:0]   aw_id_i;
  logic [7:0]                aw_len_i;

  logic                      m_aw_valid_o;
  logic                      m_aw_ready_i;
  logic [AXI_ADDR_WIDTH-1:0] m_aw_addr_o;
  logic [AXI_ID_WIDTH-1:0]   m_aw_id_o;
  logic [7:0]                m_aw_len_o;
  logic                      m_aw_coherent_o;

  logic                      s_w_valid_i;
  logic                      s_w_last_i;
  logic                      s_w_ready_o;
  logic                      m_w_valid_o;
  logic                      m_w_ready_i;

  logic                      s_b_valid_o;
  logic                      s_b_ready_i;
  logic [AXI_ID_WIDTH-1:0]   s_b_id_o;
  logic [1:0]                s_b_resp_o;

  logic                      sent_o;
  logic                      wlen_err_o;

  // Port-response block side.
  modport slave (
    input  accept_i, drop_i, miss_i, out_addr_i, coherent_i, aw_id_i, aw_len_i,
    input  m_aw_ready_i, s_w_valid_i, s_w_last_i, m_w_ready_i, s_b_ready_i,
    output m_aw_valid_o, m_aw_addr_o, m_aw_id_o, m_aw_len_o, m_aw_coherent_o,
    output s_w_ready_o, m_w_valid_o, s_b_valid_o, s_b_id_o, s_b_resp_o,
    output sent_o, wlen_err_o
  );

  // Lookup controller / AXI environment side.
  modport master (
    output accept_i, drop_i, miss_i, out_addr_i, coherent_i, aw_id_i, aw_len_i,
    output m_aw_ready_i, s_w_valid_i, s_w_last_i, m_w_ready_i, s_b_ready_i,
    input  m_aw_valid_o, m_aw_addr_o, m_aw_id_o, m_aw_len_o, m_aw_coherent_o,
    input  s_w_ready_o, m_w_valid_o, s_b_valid_o, s_b_id_o, s_b_resp_o,
    input  sent_o, wlen_err_o
  );

endinterface

// File: rtl/rab_wr_port_resp.sv
// Per-write-port consumer of RAB lookup decisions: forwards accepted AW/W bursts or sinks dropped ones with an error B.
// Optional beat-count checking is enabled with the RAB_WLAST_CHECK_EN macro.
//
// state  | meaning
// IDLE   | waiting for accept_i / drop_i from the lookup controller
// FWD_AW | presenting translated AW on the master side
// FWD_W  | passing W beats slave -> master until WLAST
// DROP_W | sinking W beats of a rejected burst until WLAST
// DROP_B | returning the error B response to the slave side
module rab_wr_port_resp
  import rab_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 40,
  parameter int AXI_ID_WIDTH   = 8
) (
  input logic             Clk_CI,
  input logic             Rst_RI,
  rab_wr_port_resp_if.slave bus
);

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [7:0]                len_q;
  logic                      coherent_q;
  logic [1:0]                resp_q;
  logic                      sent_q, sent_d;

  logic capture_accept, capture_drop, w_beat;
  logic aw_valid, w_ready, w_valid, b_valid;

  always_comb begin
    state_d        = state_q;
    sent_d         = 1'b0;
    capture_accept = 1'b0;
    capture_drop   = 1'b0;
    w_beat         = 1'b0;
    aw_valid       = 1'b0;
    w_ready        = 1'b0;
    w_valid        = 1'b0;
    b_valid        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.accept_i) begin
          capture_accept = 1'b1;
          state_d        = FWD_AW;
        end else if (bus.drop_i) begin
          capture_drop = 1'b1;
          state_d      = DROP_W;
        end
      end
      FWD_AW: begin
        aw_valid = 1'b1;
        if (bus.m_aw_ready_i) state_d = FWD_W;
      end
      FWD_W: begin
        w_valid = bus.s_w_valid_i;
        w_ready = bus.m_w_ready_i;
        w_beat  = bus.s_w_valid_i & bus.m_w_ready_i;
        if (w_beat && bus.s_w_last_i) begin
          state_d = IDLE;
          sent_d  = 1'b1;
        end
      end
      DROP_W: begin
        w_ready = 1'b1;
        w_beat  = bus.s_w_valid_i;
        if (w_beat && bus.s_w_last_i) state_d = DROP_B;
      end
      DROP_B: begin
        b_valid = 1'b1;
        if (bus.s_b_ready_i) begin
          state_d = IDLE;
          sent_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RAB_WLAST_CHECK_EN
  logic [8:0] beat_cnt_q;
  logic       wlen_err_q;
  logic       beat_mismatch;

  // Remaining beats after the current one; WLAST must coincide with zero.
  assign beat_mismatch = w_beat & (bus.s_w_last_i ? (beat_cnt_q != 9'd0) : (beat_cnt_q == 9'd0));

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      beat_cnt_q <= 9'd0;
      wlen_err_q <= 1'b0;
    end else begin
      if (capture_accept || capture_drop) begin
        beat_cnt_q <= {1'b0, bus.aw_len_i};
      end else if (w_beat && beat_cnt_q != 9'd0) begin
        beat_cnt_q <= beat_cnt_q - 9'd1;
      end
      if (beat_mismatch) wlen_err_q <= 1'b1;
    end
  end

  assign bus.wlen_err_o = wlen_err_q;
`else
  assign bus.wlen_err_o = 1'b0;
`endif

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q    <= IDLE;
      sent_q     <= 1'b0;
      addr_q     <= '0;
      id_q       <= '0;
      len_q      <= '0;
      coherent_q <= 1'b0;
      resp_q     <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      if (capture_accept) begin
        addr_q     <= bus.out_addr_i;
        id_q       <= bus.aw_id_i;
        len_q      <= bus.aw_len_i;
        coherent_q <= bus.coherent_i;
      end else if (capture_drop) begin
        id_q   <= bus.aw_id_i;
        len_q  <= bus.aw_len_i;
        resp_q <= drop_resp(bus.miss_i);
      end
`ifdef RAB_WLAST_CHECK_EN
      if (state_q == DROP_W && beat_mismatch) resp_q <= RESP_SLVERR;
`endif
    end
  end

  assign bus.m_aw_valid_o    = aw_valid;
  assign bus.m_aw_addr_o     = addr_q;
  assign bus.m_aw_id_o       = id_q;
  assign bus.m_aw_len_o      = len_q;
  assign bus.m_aw_coherent_o = coherent_q;
  assign bus.s_w_ready_o     = w_ready;
  assign bus.m_w_valid_o     = w_valid;
  assign bus.s_b_valid_o     = b_valid;
  assign bus.s_b_id_o        = id_q;
  assign bus.s_b_resp_o      = resp_q;
  assign bus.sent_o          = sent_q;

  // The lookup controller must issue one decision at a time, and only when this port is idle.
  a_single_decision : assert property (@(posedge Clk_CI) disable iff (Rst_RI)
    !(bus.accept_i && bus.drop_i));
  a_decision_in_idle : assert property (@(posedge Clk_CI) disable iff (Rst_RI)
    (bus.accept_i || bus.drop_i) |-> (state_q == IDLE));

endmodule
